// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        WAIT = 2'b01,
        ERR  = 2'b10
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load now in EX.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic       use_rs_id,
    input  logic       use_rt_id,
    input  logic [4:0] rw_ex,
    input  logic       wreg_ex,
    input  logic       rmem_ex,
    output logic       lu
);

    logic load_ex;
    logic hit_rs;
    logic hit_rt;

    // r0 is hardwired, so a load targeting it never creates a hazard
    assign load_ex = rmem_ex & wreg_ex & (rw_ex != REG_ZERO);
    assign hit_rs  = use_rs_id & (rs_id == rw_ex);
    assign hit_rt  = use_rt_id & (rt_id == rw_ex);
    assign lu      = load_ex & (hit_rs | hit_rt);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage enables, bubbles, flush,
// data-memory wait/timeout FSM and saturating stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             use_rs_id,
    input  logic             use_rt_id,
    input  logic [4:0]       rw_ex,
    input  logic             wreg_ex,
    input  logic             rmem_ex,
    input  logic             rmem_me,
    input  logic             wmem_me,
    input  logic             dmem_ack,
    input  logic             branch_taken_id,
    output logic             en_pc,
    output logic             en_ifid,
    output logic             en_idex,
    output logic             en_exme,
    output logic             en_mewb,
    output logic             bubble_idex,
    output logic             bubble_mewb,
    output logic             flush_ifid,
    output logic             dmem_req,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t          state;
    state_t          state_nxt;
    logic [WC_W-1:0] wait_cnt;
    logic [WC_W-1:0] wait_nxt;
    logic            lu;
    logic            memop_me;
    logic            err;
    logic            ms;

    load_use_detect u_lud (
        .rs_id     (rs_id),
        .rt_id     (rt_id),
        .use_rs_id (use_rs_id),
        .use_rt_id (use_rt_id),
        .rw_ex     (rw_ex),
        .wreg_ex   (wreg_ex),
        .rmem_ex   (rmem_ex),
        .lu        (lu)
    );

    assign memop_me = rmem_me | wmem_me;
    assign err      = (state == ERR);
    assign ms       = memop_me & ~dmem_ack & ~err;
    assign bus_err  = err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        unique case (state)
            RUN: begin
                wait_nxt = '0;
                if (ms) state_nxt = WAIT;
            end
            WAIT: begin
                // a late ack beats the timeout in the same cycle
                if (dmem_ack) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else if (wait_cnt == WC_LAST) begin
                    state_nxt = ERR;
                end else begin
                    wait_nxt = wait_cnt + WC_W'(1);
                end
            end
            ERR:     state_nxt = ERR;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        en_pc       = 1'b0;
        en_ifid     = 1'b0;
        en_idex     = 1'b0;
        en_exme     = 1'b0;
        en_mewb     = 1'b0;
        bubble_idex = 1'b0;
        bubble_mewb = 1'b0;
        flush_ifid  = 1'b0;
        dmem_req    = memop_me & ~err;
        if (!err) begin
            priority case (1'b1)
                ms: begin
                    // WB drains a nop so it never repeats a write
                    en_mewb     = 1'b1;
                    bubble_mewb = 1'b1;
                end
                lu: begin
                    en_idex     = 1'b1;
                    en_exme     = 1'b1;
                    en_mewb     = 1'b1;
                    bubble_idex = 1'b1;
                end
                branch_taken_id: begin
                    en_pc      = 1'b1;
                    en_ifid    = 1'b1;
                    en_idex    = 1'b1;
                    en_exme    = 1'b1;
                    en_mewb    = 1'b1;
                    flush_ifid = 1'b1;
                end
                default: begin
                    en_pc   = 1'b1;
                    en_ifid = 1'b1;
                    en_idex = 1'b1;
                    en_exme = 1'b1;
                    en_mewb = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (!en_pc && !err && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a cycle-level reference model.
module tb_pipe_ctrl;

    localparam int TO = 4;
    localparam int CW = 3;
    localparam int SAT = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    rs_id, rt_id, rw_ex;
    logic          use_rs_id, use_rt_id;
    logic          wreg_ex, rmem_ex, rmem_me, wmem_me;
    logic          dmem_ack, branch_taken_id;
    logic          en_pc, en_ifid, en_idex, en_exme, en_mewb;
    logic          bubble_idex, bubble_mewb, flush_ifid;
    logic          dmem_req, bus_err;
    logic [CW-1:0] stall_cnt;

    int vecs = 0;
    int bad  = 0;

    // reference model state, in the spec's own terms
    bit m_err;
    bit m_pend;
    int m_waited;
    int m_stalls;

    always #5 clock = ~clock;

    pipe_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clock           (clock),
        .reset           (reset),
        .rs_id           (rs_id),
        .rt_id           (rt_id),
        .use_rs_id       (use_rs_id),
        .use_rt_id       (use_rt_id),
        .rw_ex           (rw_ex),
        .wreg_ex         (wreg_ex),
        .rmem_ex         (rmem_ex),
        .rmem_me         (rmem_me),
        .wmem_me         (wmem_me),
        .dmem_ack        (dmem_ack),
        .branch_taken_id (branch_taken_id),
        .en_pc           (en_pc),
        .en_ifid         (en_ifid),
        .en_idex         (en_idex),
        .en_exme         (en_exme),
        .en_mewb         (en_mewb),
        .bubble_idex     (bubble_idex),
        .bubble_mewb     (bubble_mewb),
        .flush_ifid      (flush_ifid),
        .dmem_req        (dmem_req),
        .bus_err         (bus_err),
        .stall_cnt       (stall_cnt)
    );

    logic [9:0] dut_vec;
    assign dut_vec = {en_pc, en_ifid, en_idex, en_exme, en_mewb,
                      bubble_idex, bubble_mewb, flush_ifid,
                      dmem_req, bus_err};

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    function automatic bit model_lu();
        bit rs_hit, rt_hit;
        rs_hit = use_rs_id && rs_id == rw_ex;
        rt_hit = use_rt_id && rt_id == rw_ex;
        return rmem_ex && wreg_ex && rw_ex != 0 && (rs_hit || rt_hit);
    endfunction

    function automatic logic [9:0] model_out();
        bit memop, stall_mem;
        memop = rmem_me || wmem_me;
        stall_mem = memop && !dmem_ack;
        if (m_err) return 10'b00000_000_0_1;
        if (stall_mem) return {8'b00001_010, 1'b1, 1'b0};
        if (model_lu()) return {8'b00111_100, memop, 1'b0};
        if (branch_taken_id) return {8'b11111_001, memop, 1'b0};
        return {8'b11111_000, memop, 1'b0};
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_err = 0; m_pend = 0; m_waited = 0; m_stalls = 0;
        end else begin
            logic [9:0] o;
            o = model_out();
            if (!m_err && !o[9] && m_stalls < SAT) m_stalls++;
            if (m_err) begin
            end else if (m_pend) begin
                if (dmem_ack) m_pend = 0;
                else begin
                    m_waited++;
                    if (m_waited == TO) m_err = 1;
                end
            end else if ((rmem_me || wmem_me) && !dmem_ack) begin
                m_pend = 1;
                m_waited = 0;
            end
        end
    end

    always @(negedge clock) begin
        chk("strobes", dut_vec, model_out());
        chk("stall_cnt", stall_cnt, m_stalls);
    end

    task automatic clr();
        rs_id = 0; rt_id = 0; rw_ex = 0;
        use_rs_id = 0; use_rt_id = 0;
        wreg_ex = 0; rmem_ex = 0; rmem_me = 0; wmem_me = 0;
        dmem_ack = 0; branch_taken_id = 0;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_lu();
        rmem_ex = 1; wreg_ex = 1; rw_ex = 5'd8;
        use_rs_id = 1; rs_id = 5'd8;
    endtask

    initial begin
        clr();
        #12;
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_en_pc", en_pc, 1);
        #11 reset = 0;
        tick();

        set_lu(); #1;
        chk("lu_en_pc", en_pc, 0);
        chk("lu_bubble_idex", bubble_idex, 1);
        chk("lu_en_idex", en_idex, 1);
        tick();
        chk("lu_cnt", stall_cnt, 1);
        clr(); #1;
        chk("lu_after_en", {en_pc, en_ifid, en_idex}, 3'b111);
        tick();

        set_lu(); rw_ex = 0; rs_id = 0; #1;
        chk("lu_r0", en_pc, 1);
        tick(); clr();
        set_lu(); use_rs_id = 0; #1;
        chk("lu_nouse", en_pc, 1);
        tick(); clr();
        set_lu(); use_rs_id = 0; use_rt_id = 1; rt_id = 5'd8; #1;
        chk("lu_rt", en_pc, 0);
        tick(); clr();
        chk("lu_rt_cnt", stall_cnt, 2);

        wmem_me = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_en_exme", en_exme, 0);
            chk("st_bub_mewb", bubble_mewb, 1);
            chk("st_req", dmem_req, 1);
            tick();
        end
        dmem_ack = 1; #1;
        chk("st_ack_en", en_exme, 1);
        chk("st_ack_req", dmem_req, 1);
        tick(); clr();
        chk("st_cnt", stall_cnt, 5);

        wmem_me = 1; dmem_ack = 1; #1;
        chk("zw_en_pc", en_pc, 1);
        tick(); clr();
        dmem_ack = 1; #1;
        chk("stray_ack", {en_pc, dmem_req}, 2'b10);
        tick(); clr();

        set_lu(); branch_taken_id = 1; #1;
        chk("br_lu_flush", flush_ifid, 0);
        chk("br_lu_en_pc", en_pc, 0);
        tick(); clr();
        branch_taken_id = 1; #1;
        chk("br_flush", flush_ifid, 1);
        chk("br_en_pc", en_pc, 1);
        tick(); clr();

        rmem_me = 1;
        tick(4);
        dmem_ack = 1; #1;
        chk("ack4_en_pc", en_pc, 1);
        tick(); clr();
        chk("ack4_bus_err", bus_err, 0);
        chk("sat_cnt", stall_cnt, SAT);

        rmem_me = 1;
        tick(3);
        #2 reset = 1;
        rmem_me = 0;
        #1;
        chk("mid_rst_cnt", stall_cnt, 0);
        chk("mid_rst_err", bus_err, 0);
        chk("mid_rst_req", dmem_req, 0);
        @(negedge clock);
        #1 reset = 0;
        tick();

        rmem_me = 1;
        tick(4);
        chk("to_pre_err", bus_err, 0);
        tick();
        chk("to_bus_err", bus_err, 1);
        chk("to_en", {en_pc, en_ifid, en_idex, en_exme, en_mewb}, 0);
        chk("to_req", dmem_req, 0);
        chk("to_cnt", stall_cnt, 5);
        dmem_ack = 1;
        tick();
        chk("to_sticky", bus_err, 1);
        chk("to_cnt_hold", stall_cnt, 5);
        clr();
        #2 reset = 1;
        #1;
        chk("to_rst_err", bus_err, 0);
        @(negedge clock);
        #1 reset = 0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end

endmodule
